// File: rtl/snake_motion_engine.sv
// snake_motion_engine: snake head motion, wall/food detection and BCD score for the snake game
module snake_motion_engine #(
    parameter int CELL     = 10,
    parameter int X_MAX    = 630,
    parameter int Y_MAX    = 470,
    parameter int START_X  = 320,
    parameter int START_Y  = 240,
    parameter int TICK_DIV = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] move_state,
    input  logic [9:0] food_x,
    input  logic [9:0] food_y,
    output logic [9:0] head_x,
    output logic [9:0] head_y,
    output logic       eat_pulse,
    output logic       game_over,
    output logic       running,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] score3,
    output logic [3:0] score4
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic signed [10:0] STEP = 11'(CELL);
    localparam logic signed [10:0] XM   = 11'(X_MAX);
    localparam logic signed [10:0] YM   = 11'(Y_MAX);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] dir_q, dir_d, new_dir;
    logic [9:0] hx_q, hx_d, hy_q, hy_d;
    logic [15:0] score_q, score_d, score_inc;
    logic [4:0] c;
    logic eat_q, eat_d, start_d_q;
    logic start_rise, tick, wall, hit, sat;
    logic signed [10:0] nx, ny;
    // up/down and left/right codes differ only in bit 0, so a reversal is dir ^ 01
    always_comb begin
        start_rise = start & ~start_d_q;
        tick       = state_q == RUN && cnt_q == CW'(TICK_DIV - 1);
        new_dir    = ((move_state ^ dir_q) == 2'b01) ? dir_q : move_state;
        nx         = $signed({1'b0, hx_q}) + (new_dir == 2'b11 ? STEP : new_dir == 2'b10 ? -STEP : 11'sd0);
        ny         = $signed({1'b0, hy_q}) + (new_dir == 2'b01 ? STEP : new_dir == 2'b00 ? -STEP : 11'sd0);
        wall       = nx[10] || nx > XM || ny[10] || ny > YM;
        hit        = nx[9:0] == food_x && ny[9:0] == food_y;
        sat        = score_q == 16'h9999;
        c[0]       = 1'b1;
        score_inc  = score_q;
        for (int k = 0; k < 4; k++) begin
            score_inc[4*k +: 4] = c[k] ? (score_q[4*k +: 4] == 4'd9 ? 4'd0 : score_q[4*k +: 4] + 4'd1) : score_q[4*k +: 4];
            c[k+1]              = c[k] && score_q[4*k +: 4] == 4'd9;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        score_d = score_q;
        eat_d   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = start_rise ? RUN : IDLE;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    dir_d   = new_dir;
                    state_d = wall ? OVER : RUN;
                    hx_d    = wall ? hx_q : nx[9:0];
                    hy_d    = wall ? hy_q : ny[9:0];
                    eat_d   = !wall && hit;
                    score_d = (!wall && hit && !sat) ? score_inc : score_q;
                end
            end
            OVER: begin
                if (start_rise) begin
                    state_d = IDLE;
                    dir_d   = 2'b11;
                    hx_d    = 10'(START_X);
                    hy_d    = 10'(START_Y);
                    score_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 2'b11;
            hx_q      <= 10'(START_X);
            hy_q      <= 10'(START_Y);
            score_q   <= '0;
            eat_q     <= 1'b0;
            start_d_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            hx_q      <= hx_d;
            hy_q      <= hy_d;
            score_q   <= score_d;
            eat_q     <= eat_d;
            start_d_q <= start;
        end
    end
    assign head_x    = hx_q;
    assign head_y    = hy_q;
    assign eat_pulse = eat_q;
    assign game_over = state_q == OVER;
    assign running   = state_q == RUN;
    assign score1    = score_q[3:0];
    assign score2    = score_q[7:4];
    assign score3    = score_q[11:8];
    assign score4    = score_q[15:12];
endmodule
